// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a shared combinational add/sub ALU.
// Requests are latched on accept; the ALU result is registered into a tagged response.
module addsub_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  // state | meaning
  // IDLE  | arbitrate req_valid, accept one request
  // EXEC  | latched operands on the ALU, result captured at the edge
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic             lastGrant;
  logic             grantId;
  logic             accept;
  logic             opLegal;
  logic [WIDTH-1:0] selA;
  logic [WIDTH-1:0] selB;
  logic [OPW-1:0]   selOp;

  logic [WIDTH-1:0] latA;
  logic [WIDTH-1:0] latB;
  logic [OPW-1:0]   latOp;
  logic             latId;
  logic [WIDTH-1:0] rspData;
  logic             rspOvf;
  logic             rspErr;

  // Contention goes to whoever did not win last; lastGrant resets to 1 so req0 wins first.
  always_comb begin
    grantId = 1'b0;
    case (req_valid)
      2'b01:   grantId = 1'b0;
      2'b10:   grantId = 1'b1;
      2'b11:   grantId = ~lastGrant;
      default: grantId = 1'b0;
    endcase
  end

  assign selA    = grantId ? req1_a  : req0_a;
  assign selB    = grantId ? req1_b  : req0_b;
  assign selOp   = grantId ? req1_op : req0_op;
  assign opLegal = (selOp[OPW-1:1] == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // req_ready is also gated by reset_n so it reads 0 while reset is held.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    req_ready = 2'b00;
    case (state)
      IDLE: begin
        if ((|req_valid) && reset_n) begin
          accept    = 1'b1;
          req_ready = grantId ? 2'b10 : 2'b01;
          stateNext = opLegal ? EXEC : RESP;
        end
      end
      EXEC: begin
        stateNext = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lastGrant <= 1'b1;
      latA      <= '0;
      latB      <= '0;
      latOp     <= '0;
      latId     <= 1'b0;
      rspData   <= '0;
      rspOvf    <= 1'b0;
      rspErr    <= 1'b0;
    end else begin
      if (accept) begin
        latA      <= selA;
        latB      <= selB;
        latOp     <= selOp;
        latId     <= grantId;
        lastGrant <= grantId;
        if (!opLegal) begin
          rspData <= '0;
          rspOvf  <= 1'b0;
          rspErr  <= 1'b1;
        end
      end
      if (state == EXEC) begin
        rspData <= alu_result;
        rspOvf  <= alu_ovf;
        rspErr  <= 1'b0;
      end
    end
  end

  assign alu_a     = latA;
  assign alu_b     = latB;
  assign alu_op    = latOp;
  assign alu_en    = (state == EXEC);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = latId;
  assign rsp_data  = rspData;
  assign rsp_ovf   = rspOvf;
  assign rsp_err   = rspErr;

endmodule
